// File: rtl/syn_m_frame_ctrl.sv
// Sync frame sequencer: on each accepted sync pulse, captures the measured pulse
// period (in us) and emits HEAD, PERIOD[15:8], PERIOD[7:0], SEQ on the TX byte
// channel, one byte per TX handshake.
module syn_m_frame_ctrl #(
    parameter logic [7:0]  HEAD       = 8'hA5,
    parameter logic [15:0] TIMEOUT_US = 16'd50
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       en,
    input  logic       pluse,
    input  logic       pluse_us,
    input  logic       done_tx,
    input  logic       clr_err,
    output logic       fire_tx,
    output logic [7:0] data_tx,
    output logic       busy,
    output logic [7:0] seq,
    output logic       overrun,
    output logic       timeout_err
);

    // state  | meaning
    // -------+----------------------------------------------------------
    // IDLE   | no frame in progress, waiting for an enabled sync pulse
    // FIRE   | one-cycle transmit strobe for the byte selected by idx
    // WAIT   | waiting for done_tx; us ticks counted towards timeout
    // NEXT   | advance to the next byte, or close the frame after byte 3
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_WAIT = 2'd2,
        S_NEXT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] per_cnt_q, per_cnt_d;
    logic [15:0] period_q, period_d;
    logic [15:0] tmo_q, tmo_d;
    logic [15:0] tmo_inc;
    logic [7:0]  data_q, data_d;
    logic [7:0]  seq_q, seq_d;
    logic        ovr_q, ovr_d;
    logic        tmo_err_q, tmo_err_d;
    logic        tmo_hit;
    logic [1:0]  idx_nxt;

    // Byte carried at a given frame position.
    function automatic logic [7:0] byte_sel(input logic [1:0] i,
                                            input logic [15:0] per,
                                            input logic [7:0] s);
        logic [7:0] b;
        case (i)
            2'd0:    b = HEAD;
            2'd1:    b = per[15:8];
            2'd2:    b = per[7:0];
            default: b = s;
        endcase
        return b;
    endfunction

    assign tmo_inc = tmo_q + 16'd1;
    assign idx_nxt = idx_q + 2'd1;

    // Free-running period counter; a pulse restarts it and, when a frame is
    // accepted, snapshots the elapsed count. A tick coinciding with a pulse
    // is discarded so the new period starts from exactly zero.
    always_comb begin
        per_cnt_d = per_cnt_q;
        period_d  = period_q;
        if (pluse) begin
            per_cnt_d = 16'd0;
            if ((state_q == S_IDLE) && en) begin
                period_d = per_cnt_q;
            end
        end else if (pluse_us && (per_cnt_q != 16'hFFFF)) begin
            per_cnt_d = per_cnt_q + 16'd1;
        end
    end

    // Frame sequencing: next state, byte index, outgoing byte, SEQ and the
    // done_tx watchdog. done_tx wins over a timeout landing in the same cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        seq_d   = seq_q;
        tmo_d   = tmo_q;
        tmo_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pluse && en) begin
                    state_d = S_FIRE;
                    idx_d   = 2'd0;
                    data_d  = HEAD;
                end
            end
            S_FIRE: begin
                state_d = S_WAIT;
                tmo_d   = 16'd0;
            end
            S_WAIT: begin
                if (done_tx) begin
                    state_d = S_NEXT;
                end else if (pluse_us) begin
                    if (tmo_inc >= TIMEOUT_US) begin
                        state_d = S_IDLE;
                        idx_d   = 2'd0;
                        tmo_hit = 1'b1;
                    end else begin
                        tmo_d = tmo_inc;
                    end
                end
            end
            S_NEXT: begin
                if (idx_q != 2'd3) begin
                    state_d = S_FIRE;
                    idx_d   = idx_nxt;
                    data_d  = byte_sel(idx_nxt, period_q, seq_q);
                end else begin
                    state_d = S_IDLE;
                    idx_d   = 2'd0;
                    seq_d   = seq_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // Sticky error flags; a set event in the same cycle as clr_err wins.
    always_comb begin
        ovr_d     = ovr_q;
        tmo_err_d = tmo_err_q;
        if (clr_err) begin
            ovr_d     = 1'b0;
            tmo_err_d = 1'b0;
        end
        if (pluse && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end
        if (tmo_hit) begin
            tmo_err_d = 1'b1;
        end
    end

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            per_cnt_q <= 16'd0;
            period_q  <= 16'd0;
            tmo_q     <= 16'd0;
            data_q    <= 8'd0;
            seq_q     <= 8'd0;
            ovr_q     <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            per_cnt_q <= per_cnt_d;
            period_q  <= period_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            seq_q     <= seq_d;
            ovr_q     <= ovr_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign fire_tx     = (state_q == S_FIRE);
    assign busy        = (state_q != S_IDLE);
    assign data_tx     = data_q;
    assign seq         = seq_q;
    assign overrun     = ovr_q;
    assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_syn_m_frame_ctrl.sv
// Bench for syn_m_frame_ctrl: table vectors, hand-written corner sequences and
// randomized frames checked against a behavioural model of elapsed us ticks.
module tb_syn_m_frame_ctrl;

    logic       clk_sys = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       pluse = 1'b0;
    logic       pluse_us = 1'b0;
    logic       done_tx = 1'b0;
    logic       clr_err = 1'b0;
    logic       fire_tx;
    logic [7:0] data_tx;
    logic       busy;
    logic [7:0] seq;
    logic       overrun;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    // Model state: ticks seen since the last pulse, period captured by the
    // last pulse (saturated to 16 bits) and the expected SEQ value.
    int          m_cnt = 0;
    logic [15:0] m_last = 16'd0;
    logic [7:0]  m_seq = 8'd0;

    typedef struct {
        int          ticks;
        bit          en;
        int          dly;
        bit          drop;
        logic [15:0] per;
    } vec_t;

    vec_t vt[7];

    syn_m_frame_ctrl dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .en         (en),
        .pluse      (pluse),
        .pluse_us   (pluse_us),
        .done_tx    (done_tx),
        .clr_err    (clr_err),
        .fire_tx    (fire_tx),
        .data_tx    (data_tx),
        .busy       (busy),
        .seq        (seq),
        .overrun    (overrun),
        .timeout_err(timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  = 0;
            m_last = 16'd0;
        end else if (pluse) begin
            m_last = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
            m_cnt  = 0;
        end else if (pluse_us) begin
            m_cnt = m_cnt + 1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        if (n > 0) begin
            pluse_us = 1'b1;
            repeat (n) cyc();
            pluse_us = 1'b0;
        end
    endtask

    task automatic send_pulse();
        pluse = 1'b1;
        cyc();
        pluse = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_fire"}, fire_tx, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_data"}, data_tx, 8'h00);
        chk({tag, "_seq"}, seq, 8'h00);
        chk({tag, "_ovr"}, overrun, 1'b0);
        chk({tag, "_tmo"}, timeout_err, 1'b0);
    endtask

    task automatic expect_no_frame(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (fire_tx || busy) seen = 1'b1;
            cyc();
        end
        chk(tag, seen, 1'b0);
    endtask

    // Called right after the accepted pulse; runs the four handshakes.
    task automatic run_frame(input logic [15:0] per, input int dly, input bit inj,
                             input bit wtick, input bit drop_en);
        logic [7:0] exp_b[4];
        exp_b[0] = 8'hA5;
        exp_b[1] = per[15:8];
        exp_b[2] = per[7:0];
        exp_b[3] = m_seq;
        chk("first_fire", fire_tx, 1'b1);
        for (int b = 0; b < 4; b++) begin
            if (b > 0) chk($sformatf("done_to_fire%0d", b), fire_tx, 1'b1);
            chk($sformatf("byte%0d", b), data_tx, exp_b[b]);
            if (drop_en && b == 0) en = 1'b0;
            for (int d = 0; d < dly; d++) begin
                pluse_us = wtick ? 1'($urandom_range(0, 1)) : 1'b0;
                pluse    = (inj && b == 2 && d == 0);
                cyc();
                pluse    = 1'b0;
                pluse_us = 1'b0;
                if (d == 0) chk("fire_width", fire_tx, 1'b0);
            end
            chk($sformatf("hold%0d", b), data_tx, exp_b[b]);
            done_tx = 1'b1;
            cyc();
            done_tx = 1'b0;
            chk("next_no_fire", fire_tx, 1'b0);
            cyc();
        end
        m_seq = m_seq + 8'd1;
        chk("end_busy", busy, 1'b0);
        chk("end_seq", seq, m_seq);
        chk("end_tmo", timeout_err, 1'b0);
        if (drop_en) en = 1'b1;
        if (inj) begin
            chk("ovr_set", overrun, 1'b1);
            clr_err = 1'b1;
            cyc();
            clr_err = 1'b0;
            chk("ovr_clr", overrun, 1'b0);
        end else begin
            chk("ovr_none", overrun, 1'b0);
        end
    endtask

    initial begin
        vt[0] = '{ticks: 1000,  en: 1'b1, dly: 10, drop: 1'b0, per: 16'h03E8};
        vt[1] = '{ticks: 1000,  en: 1'b1, dly: 10, drop: 1'b0, per: 16'h03E8};
        vt[2] = '{ticks: 5,     en: 1'b0, dly: 3,  drop: 1'b0, per: 16'h0000};
        vt[3] = '{ticks: 7,     en: 1'b1, dly: 2,  drop: 1'b0, per: 16'h0007};
        vt[4] = '{ticks: 258,   en: 1'b1, dly: 1,  drop: 1'b1, per: 16'h0102};
        vt[5] = '{ticks: 0,     en: 1'b1, dly: 4,  drop: 1'b0, per: 16'h0000};
        vt[6] = '{ticks: 70000, en: 1'b1, dly: 3,  drop: 1'b0, per: 16'hFFFF};

        // Reset values, during and after reset.
        cyc();
        cyc();
        check_idle_outputs("rst");
        rst_n = 1'b1;
        en    = 1'b1;
        cyc();
        check_idle_outputs("post_rst");

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            en = vt[i].en;
            tick_n(vt[i].ticks);
            send_pulse();
            if (vt[i].en) begin
                run_frame(vt[i].per, vt[i].dly, 1'b0, 1'b0, vt[i].drop);
            end else begin
                expect_no_frame("en0_nofire");
                chk("en0_ovr", overrun, 1'b0);
                en = 1'b1;
            end
        end
        chk("seq_after_table", seq, 8'd6);

        // Overrun: pulse during byte 2, frame bytes unchanged, then cleared.
        tick_n(20);
        send_pulse();
        run_frame(16'd20, 4, 1'b1, 1'b0, 1'b0);
        expect_no_frame("ovr_no_extra");

        // Timeout after byte 1; set event beats clr_err in the same cycle.
        tick_n(300);
        send_pulse();
        chk("tmo_fire0", fire_tx, 1'b1);
        chk("tmo_byte0", data_tx, 8'hA5);
        cyc();
        done_tx = 1'b1;
        cyc();
        done_tx = 1'b0;
        cyc();
        chk("tmo_fire1", fire_tx, 1'b1);
        chk("tmo_byte1", data_tx, 8'h01);
        cyc();
        pluse   = 1'b1;
        clr_err = 1'b1;
        cyc();
        pluse   = 1'b0;
        clr_err = 1'b0;
        chk("set_wins_clr", overrun, 1'b1);
        pluse_us = 1'b1;
        repeat (49) cyc();
        chk("tmo_49_err", timeout_err, 1'b0);
        chk("tmo_49_busy", busy, 1'b1);
        cyc();
        pluse_us = 1'b0;
        chk("tmo_50_err", timeout_err, 1'b1);
        chk("tmo_50_busy", busy, 1'b0);
        chk("tmo_seq", seq, m_seq);
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        chk("tmo_clr", timeout_err, 1'b0);
        chk("tmo_clr_ovr", overrun, 1'b0);
        send_pulse();
        run_frame(16'd50, 2, 1'b0, 1'b0, 1'b0);

        // Pulse and tick together: tick discarded, counter restarts at zero.
        tick_n(5);
        pluse    = 1'b1;
        pluse_us = 1'b1;
        cyc();
        pluse    = 1'b0;
        pluse_us = 1'b0;
        run_frame(16'h0005, 2, 1'b0, 1'b0, 1'b0);
        send_pulse();
        run_frame(16'h0000, 1, 1'b0, 1'b0, 1'b0);

        // Randomized frames against the model.
        for (int r = 0; r < 25; r++) begin
            int n;
            bit e;
            n = $urandom_range(0, 300);
            e = ($urandom_range(0, 9) != 0);
            en = e;
            tick_n(n);
            send_pulse();
            if (e) begin
                run_frame(m_last, $urandom_range(1, 6), ($urandom_range(0, 4) == 0),
                          1'b1, ($urandom_range(0, 3) == 0));
            end else begin
                expect_no_frame("rnd_en0_nofire");
                en = 1'b1;
            end
        end

        // Reset while waiting for done_tx, with overrun set.
        tick_n(3);
        send_pulse();
        cyc();
        pluse = 1'b1;
        cyc();
        pluse = 1'b0;
        chk("pre_rst_busy", busy, 1'b1);
        chk("pre_rst_ovr", overrun, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        m_seq = 8'd0;
        cyc();
        cyc();
        rst_n = 1'b1;
        expect_no_frame("rst_no_reissue");

        // 256 frames: SEQ walks 00..FF and wraps to 00.
        for (int f = 0; f < 256; f++) begin
            send_pulse();
            run_frame(m_last, 1, 1'b0, 1'b0, 1'b0);
        end
        chk("seq_wrap", seq, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
